demux_bin_stream: RTL

DEMUX_BIN_STREAM -- requirements
Module: demux_bin_stream

---
 rtl/demux_bin_stream.sv | 104 ++++++++++
 1 files changed

// File: rtl/demux_bin_stream.sv
// demux_bin_stream: routes a valid/ready payload stream to one of WIDTH output
// lanes, selected by a binary lane index. A single-entry output register gives
// one cycle of latency and sustains one transfer per cycle.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-high reset
//   bin    binary destination lane, qualified by i_vld
//   i_vld  input payload valid
//   i_dat  input payload
//   i_rdy  input ready, combinational from o_rdy (independent of i_vld/bin)
//   o_vld  per-lane valid, one-hot or zero
//   o_dat  payload shared by all lanes
//   o_rdy  per-lane ready; only the selected lane's bit is used
//   err    one-cycle pulse after an input transfer with an out-of-range bin
module demux_bin_stream #(
    parameter type         DAT_T     = logic [8-1:0],
    parameter int unsigned WIDTH     = 32,
    localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_LOG-1:0] bin,
    input  logic                 i_vld,
    input  DAT_T                 i_dat,
    output logic                 i_rdy,
    output logic [WIDTH-1:0]     o_vld,
    output DAT_T                 o_dat,
    input  logic [WIDTH-1:0]     o_rdy,
    output logic                 err
);

    // Elaboration-time parameter check.
    if (WIDTH < 2) begin : g_width_check
        $error("demux_bin_stream: WIDTH must be >= 2");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    DAT_T                 dat_r;
    logic [WIDTH_LOG-1:0] bin_r;
    logic                 err_q;
    logic                 err_d;
    logic                 bin_legal;
    logic                 in_xfer;
    logic                 out_xfer;
    logic                 load;

    // bin_r is only ever loaded with a legal index, so o_rdy[bin_r] is in range.
    assign bin_legal = 32'(bin) < WIDTH;
    assign out_xfer  = (state_q == FULL) && o_rdy[bin_r];
    assign i_rdy     = (state_q == EMPTY) || o_rdy[bin_r];
    assign in_xfer   = i_vld && i_rdy;
    assign load      = in_xfer && bin_legal;

    // State, payload and error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            dat_r   <= '0;
            bin_r   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (load) begin
                dat_r <= i_dat;
                bin_r <= bin;
            end
        end
    end

    // Next state: a legal load always leaves the entry full (reload when draining).
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        if (load) begin
            state_d = FULL;
        end else if (out_xfer) begin
            state_d = EMPTY;
        end
        // Out-of-range selects are consumed without loading and flagged.
        if (in_xfer && !bin_legal) begin
            err_d = 1'b1;
        end
    end

    // Lane-valid decode from the stored index.
    always_comb begin
        o_vld = '0;
        if (state_q == FULL) begin
            o_vld[bin_r] = 1'b1;
        end
    end

    assign o_dat = dat_r;
    assign err   = err_q;

endmodule
